// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Optional leading-zero blanking mask is enabled by defining BIN_TO_BCD_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   wrk_q, wrk_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic               out_bit;

  // Per-digit add-3 correction; 4-bit arithmetic, no carry between digits
  always_comb begin
    adj = wrk_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (wrk_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = wrk_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[BCD_W-2:0], sr_q[WIDTH-1]};
    out_bit = adj[BCD_W-1];
  end

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_new;
  logic              zero_above;

  // Blank digit i (i>=1) when it and all higher digits of the new result are zero
  always_comb begin
    zero_above = 1'b1;
    blank_new  = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_above   = zero_above & (shifted[4*i +: 4] == 4'd0);
      blank_new[i] = zero_above;
    end
  end
`endif

  // Next-state and output computation
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    wrk_d    = wrk_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
`ifdef BIN_TO_BCD_BLANK_EN
    blank_d  = blank_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d     = bin;
          wrk_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(WIDTH);
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sr_d     = {sr_q[WIDTH-2:0], 1'b0};
        wrk_d    = shifted;
        sticky_d = sticky_q | out_bit;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted;
          ovf_d   = sticky_q | out_bit;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef BIN_TO_BCD_BLANK_EN
          blank_d = (sticky_q | out_bit) ? '0 : blank_new;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      wrk_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
      blank_q  <= ~DIGITS'(1);
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      wrk_q    <= wrk_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
`ifdef BIN_TO_BCD_BLANK_EN
      blank_q  <= blank_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
`ifdef BIN_TO_BCD_BLANK_EN
  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: 7-digit and 6-digit instances share stimulus.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] bin;

  logic        busy7, done7, ovf7;
  logic [27:0] bcd7;
  logic [6:0]  blank7;
  logic        busy6, done6, ovf6;
  logic [23:0] bcd6;
  logic [5:0]  blank6;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(20), .DIGITS(7)) dut7 (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy7), .done(done7), .bcd(bcd7), .ovf(ovf7), .blank(blank7)
  );

  bin_to_bcd_seq #(.WIDTH(20), .DIGITS(6)) dut6 (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy6), .done(done6), .bcd(bcd6), .ovf(ovf6), .blank(blank6)
  );

  typedef struct {
    logic [19:0] bin;
    logic [27:0] bcd7;
    logic        ovf7;
    logic [6:0]  blank7;
    logic [23:0] bcd6;
    logic        ovf6;
    logic [5:0]  blank6;
  } vec_t;

  vec_t vecs[8];
  vec_t v777;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] exp_blank7(input logic [6:0] b);
`ifdef BIN_TO_BCD_BLANK_EN
    return b;
`else
    return 7'd0 & b;
`endif
  endfunction

  function automatic logic [5:0] exp_blank6(input logic [5:0] b);
`ifdef BIN_TO_BCD_BLANK_EN
    return b;
`else
    return 6'd0 & b;
`endif
  endfunction

  // One full conversion with latency, result and single-pulse checks
  task automatic run_vec(input vec_t v);
    int k;
    bit seen;
    @(negedge clk);
    bin   = v.bin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 20'h5A5A5;
    check("busy_after_accept", 32'(busy7), 32'd1);
    seen = 0;
    for (k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done7) begin
        seen = 1;
        break;
      end
    end
    check("latency", 32'(k), 32'd20);
    if (seen) begin
      check("bcd7", 32'(bcd7), 32'(v.bcd7));
      check("ovf7", 32'(ovf7), 32'(v.ovf7));
      check("blank7", 32'(blank7), 32'(exp_blank7(v.blank7)));
      check("bcd6", 32'(bcd6), 32'(v.bcd6));
      check("ovf6", 32'(ovf6), 32'(v.ovf6));
      check("blank6", 32'(blank6), 32'(exp_blank6(v.blank6)));
      check("done6_aligned", 32'(done6), 32'd1);
      check("busy_low_at_done", 32'(busy7), 32'd0);
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done7), 32'd0);
      check("bcd7_held", 32'(bcd7), 32'(v.bcd7));
    end
  endtask

  initial begin
    int k, ndone, done_at, busy_hi, d1, d2;

    vecs[0] = '{20'd0,       28'h0000000, 1'b0, 7'b1111110, 24'h000000, 1'b0, 6'b111110};
    vecs[1] = '{20'd12345,   28'h0012345, 1'b0, 7'b1100000, 24'h012345, 1'b0, 6'b100000};
    vecs[2] = '{20'hFFFFF,   28'h1048575, 1'b0, 7'b0000000, 24'h048575, 1'b1, 6'b000000};
    vecs[3] = '{20'd9,       28'h0000009, 1'b0, 7'b1111110, 24'h000009, 1'b0, 6'b111110};
    vecs[4] = '{20'd10,      28'h0000010, 1'b0, 7'b1111100, 24'h000010, 1'b0, 6'b111100};
    vecs[5] = '{20'd999999,  28'h0999999, 1'b0, 7'b1000000, 24'h999999, 1'b0, 6'b000000};
    vecs[6] = '{20'd1000000, 28'h1000000, 1'b0, 7'b0000000, 24'h000000, 1'b1, 6'b000000};
    vecs[7] = '{20'd500000,  28'h0500000, 1'b0, 7'b1000000, 24'h500000, 1'b0, 6'b000000};
    v777    = '{20'd777,     28'h0000777, 1'b0, 7'b1111000, 24'h000777, 1'b0, 6'b111000};

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy7), 32'd0);
    check("rst_done", 32'(done7), 32'd0);
    check("rst_bcd", 32'(bcd7), 32'd0);
    check("rst_ovf", 32'(ovf7), 32'd0);
    check("rst_blank7", 32'(blank7), 32'(exp_blank7(7'b1111110)));
    check("rst_blank6", 32'(blank6), 32'(exp_blank6(6'b111110)));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // start re-pulsed mid-conversion must be ignored
    @(negedge clk);
    bin   = 20'd999;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("repulse_busy0", 32'(busy7), 32'd1);
    ndone = 0; done_at = 0; busy_hi = 0;
    for (k = 1; k <= 26; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 10);
      bin   = 20'd123;
      @(posedge clk); #1;
      if (done7) begin
        ndone++;
        if (done_at == 0) done_at = k;
      end
      if (k < 20 && busy7) busy_hi++;
    end
    start = 1'b0;
    check("repulse_ndone", 32'(ndone), 32'd1);
    check("repulse_done_at", 32'(done_at), 32'd20);
    check("repulse_busy_run", 32'(busy_hi), 32'd19);
    check("repulse_bcd", 32'(bcd7), 32'h0000999);
    check("repulse_idle", 32'(busy7), 32'd0);

    // reset during SHIFT aborts without a done pulse
    @(negedge clk);
    bin   = 20'd54321;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy7), 32'd0);
    check("abort_done", 32'(done7), 32'd0);
    check("abort_bcd", 32'(bcd7), 32'd0);
    check("abort_ovf", 32'(ovf7), 32'd0);
    check("abort_blank", 32'(blank7), 32'(exp_blank7(7'b1111110)));
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    ndone = 0;
    for (k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done7) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_bcd_hold", 32'(bcd7), 32'd0);
    run_vec(v777);

    // back-to-back: start held high, second accepted during done cycle
    @(negedge clk);
    bin   = 20'd42;
    start = 1'b1;
    @(posedge clk); #1;
    bin = 20'd99;
    d1 = 0; d2 = 0;
    for (k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done7) begin
        if (d1 == 0) begin
          d1 = k;
          check("b2b_first_bcd", 32'(bcd7), 32'h0000042);
        end else begin
          d2 = k;
          start = 1'b0;
          check("b2b_second_bcd", 32'(bcd7), 32'h0000099);
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_at", 32'(d1), 32'd20);
    check("b2b_spacing", 32'(d2 - d1), 32'd21);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle_after", 32'(busy7), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
